// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the digit-serial nibble adder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nibble_serial_adder_pkg;

  // Width of one digit handled per clock by the carry-skip stage.
  localparam int NIBBLE_W = 4;

  // Width of the bypassed-nibble counter; wide enough for 14 nibbles.
  localparam int SKIP_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_skip_add.sv
// 4-bit carry-skip adder: four full adders with a bypass mux on the carry-out.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module nibble_skip_add
  import nibble_serial_adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                prop,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  // Ripple chain of full adders, then bypass the chain when every bit propagates.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = p[i] ^ c[i];
      c[i+1]   = g[i] | (p[i] & c[i]);
    end
    prop = &p;
    // When all four bits propagate the ripple result equals cin; the mux
    // just gives the carry a short path around the chain.
    cout = prop ? cin : c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one nibble per clock through a shared carry-skip stage.
// Latency: done pulses in the cycle after edge k+NIBBLES for a start sampled at edge k.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  sum,
  output logic              cout,
  output logic [SKIP_W-1:0] skip_count
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [SKIP_W-1:0] acc_skip_q, acc_skip_d;

  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic [SKIP_W-1:0] skip_q;

  logic              accept;
  logic              step;
  logic              last;

  logic [NIBBLE_W-1:0] stg_sum;
  logic                stg_cout;
  logic                stg_prop;
  logic [WIDTH-1:0]    nib_ext;

  nibble_skip_add u_stage (
    .sum  (stg_sum),
    .cout (stg_cout),
    .prop (stg_prop),
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: RUN lasts exactly NIBBLES cycles, DONE lasts one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status flags decode the state register, strobes steer the datapath.
  always_comb begin
    busy   = (state_q == S_RUN) || (state_q == S_DONE);
    done   = (state_q == S_DONE);
    accept = (state_q == S_IDLE) && start;
    step   = (state_q == S_RUN);
    last   = (state_q == S_RUN) && (idx_q == LAST_IDX);
  end

  // Datapath next state: capture on accept, otherwise consume one nibble per RUN cycle.
  always_comb begin
    idx_d      = idx_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    acc_skip_d = acc_skip_q;
    nib_ext    = WIDTH'(stg_sum);
    if (accept) begin
      a_sh_d     = a;
      b_sh_d     = b;
      carry_d    = cin;
      idx_d      = '0;
      acc_skip_d = '0;
    end else if (step) begin
      a_sh_d     = a_sh_q >> NIBBLE_W;
      b_sh_d     = b_sh_q >> NIBBLE_W;
      // New nibble enters at the top so after NIBBLES shifts nibble 0 sits at the bottom.
      sum_sh_d   = (sum_sh_q >> NIBBLE_W) | (nib_ext << (WIDTH - NIBBLE_W));
      carry_d    = stg_cout;
      acc_skip_d = acc_skip_q + SKIP_W'(stg_prop);
      idx_d      = idx_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      acc_skip_q <= '0;
    end else begin
      idx_q      <= idx_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      acc_skip_q <= acc_skip_d;
    end
  end

  // Result registers: loaded only on the edge that raises done, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      skip_q <= '0;
    end else if (last) begin
      sum_q  <= sum_sh_d;
      cout_q <= stg_cout;
      skip_q <= acc_skip_d;
    end
  end

  assign sum        = sum_q;
  assign cout       = cout_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a cycle-level reference model.
// Latency: checks done timing at NIBBLES+1 cycles and NIBBLES+2 throughput.
// Backpressure: exercises ignored starts in RUN/DONE and continuous start.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic [3:0]    skip_count;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count of nibble positions whose operand digits differ in every bit.
  function automatic logic [3:0] model_skip(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [3:0] n = 0;
    for (int i = 0; i < N; i++)
      if (((x >> (4*i)) ^ (y >> (4*i))) % 16 == 15) n++;
    return n;
  endfunction

  // Reference model: m_t counts edges since acceptance (0 = idle).
  int         m_t = 0;
  logic [W:0] p_res = '0;
  logic [3:0] p_skip = '0;
  logic [W:0] m_res = '0;
  logic [3:0] m_skip = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_res = '0; m_skip = '0;
    end else if (m_t == 0) begin
      if (start) begin
        p_res  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        p_skip = model_skip(a, b);
        m_t    = 1;
      end
    end else begin
      m_t++;
      if (m_t == N + 1) begin
        m_res  = p_res;
        m_skip = p_skip;
      end else if (m_t == N + 2) begin
        m_t = 0;
      end
    end
  end

  // Every cycle: all outputs against the model, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    chk("busy", 32'(busy), 32'(m_t != 0));
    chk("done", 32'(done), 32'(m_t == N + 1));
    chk("sum", 32'(sum), 32'(m_res[W-1:0]));
    chk("cout", 32'(cout), 32'(m_res[W]));
    chk("skip_count", 32'(skip_count), 32'(m_skip));
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic [3:0] esk);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(N + 1));
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_skip", 32'(skip_count), 32'(esk));
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_done;
    int last_done;
    int cyc;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_skip", 32'(skip_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'd0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd4);
    do_op(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 4'd4);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'd0);

    // Starts during RUN and DONE must be dropped.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    chk("ign_sum", 32'(sum), 32'h0002);
    chk("ign_cout", 32'(cout), 32'd0);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_no_second_done", 32'(ndone), 32'd0);
    chk("ign_sum_hold", 32'(sum), 32'h0002);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'd1);

    // Continuous start: one accept every N+2 cycles.
    @(negedge clk);
    start = 1'b1;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
    ndone = 0; first_done = -1; last_done = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) first_done = i;
        else chk("b2b_interval", 32'(i - last_done), 32'(N + 2));
        last_done = i;
        ndone++;
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(first_done), 32'(N));
    chk("b2b_count", 32'(ndone), 32'd4);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
